// File: rtl/seg_scan_display_pkg.sv
// Shared constants, segment glyphs and the latched-result payload for the
// seven-segment scan display stage.
package seg_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned FLAG_W     = 3;
    localparam int unsigned RESULT_W   = SEG_W + 1 + FLAG_W;

    // Bit positions inside the flag word {carry, overflow, nonzero}
    localparam int unsigned FLAG_CARRY = 2;
    localparam int unsigned FLAG_OV    = 1;
    localparam int unsigned FLAG_NZ    = 0;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_ONE   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;

    typedef struct packed {
        logic [SEG_W-1:0]  seg;
        logic              neg_n;
        logic [FLAG_W-1:0] flags;
    } result_t;

    localparam result_t RESULT_RST = '{seg: SEG_BLANK, neg_n: 1'b1, flags: 3'b000};

    // One-hot-low anode enable for a digit index
    function automatic logic [NUM_DIGITS-1:0] digit_enable_n(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Arithmetic-result input and display-drive outputs of the scan display stage.
interface seg_scan_display_if;
    import seg_scan_pkg::*;

    logic [SEG_W-1:0]      seg_in;
    logic                  neg_n;
    logic [FLAG_W-1:0]     flags;
    logic [NUM_DIGITS-1:0] an_n;
    logic [SEG_W-1:0]      seg_out;
    logic                  dp_n;
    logic                  ov_led;
    logic                  upd;

    modport master (
        output seg_in, neg_n, flags,
        input  an_n, seg_out, dp_n, ov_led, upd
    );

    modport slave (
        input  seg_in, neg_n, flags,
        output an_n, seg_out, dp_n, ov_led, upd
    );

endinterface

// File: rtl/seg_scan_display_in_stable.sv
// Two-flop synchroniser followed by a stability filter: a word is latched,
// with a one-cycle upd pulse, once it has been unchanged for STABLE_CYC cycles.
module in_stable #(
    parameter int unsigned   W          = 1,
    parameter int unsigned   STABLE_CYC = 16,
    parameter logic [W-1:0]  RST_VAL    = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         upd_o
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);

    logic [W-1:0]     meta_q;
    logic [W-1:0]     sync_q;
    logic [W-1:0]     sync_dly_q;
    logic [W-1:0]     hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             upd_q, upd_d;

    // Count saturates so a held value loads exactly once
    always_comb begin
        cnt_d  = cnt_q;
        hold_d = hold_q;
        upd_d  = 1'b0;
        if (sync_q != sync_dly_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STABLE_CYC)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
                hold_d = sync_q;
                upd_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= RST_VAL;
            sync_q     <= RST_VAL;
            sync_dly_q <= RST_VAL;
            hold_q     <= RST_VAL;
            cnt_q      <= '0;
            upd_q      <= 1'b0;
        end else begin
            meta_q     <= din_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            upd_q      <= upd_d;
        end
    end

    assign dout_o = hold_q;
    assign upd_o  = upd_q;

endmodule

// File: rtl/seg_scan_display.sv
// Debounces/latches the add-sub result and scans it onto a 4-digit common-anode
// display. Define SEG_SCAN_BLINK_EN to blink digits 0 and 3 while overflow is latched.
module seg_scan_display
    import seg_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned STABLE_CYC   = 16,
    parameter int unsigned BLINK_FRAMES = 25
) (
    input  logic               clk,
    input  logic               clrn,
    seg_scan_display_if.slave  bus
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    if (SCAN_DIV < 2) begin : g_chk_div
        $error("SCAN_DIV must be at least 2");
    end
    if (STABLE_CYC < 1) begin : g_chk_stable
        $error("STABLE_CYC must be at least 1");
    end
    if (BLINK_FRAMES < 1) begin : g_chk_blink
        $error("BLINK_FRAMES must be at least 1");
    end

    result_t din_c;
    result_t lat_c;
    logic    upd_c;

    assign din_c = '{seg: bus.seg_in, neg_n: bus.neg_n, flags: bus.flags};

    in_stable #(
        .W          (RESULT_W),
        .STABLE_CYC (STABLE_CYC),
        .RST_VAL    (RESULT_RST)
    ) u_in_stable (
        .clk    (clk),
        .rst_n  (clrn),
        .din_i  (din_c),
        .dout_o (lat_c),
        .upd_o  (upd_c)
    );

    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             digit_wrap_c;

    assign digit_wrap_c = (div_q == DIV_W'(SCAN_DIV - 1));

    // Digit dwell divider and scan index
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (digit_wrap_c) begin
            div_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               blink_q, blink_d;
    logic               frame_end_c;
    logic               blank_c;

    assign frame_end_c = digit_wrap_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // Blink phase free-runs; it only takes effect while overflow is latched
    always_comb begin
        frame_d = frame_q;
        blink_d = blink_q;
        if (frame_end_c) begin
            if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            frame_q <= '0;
            blink_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            blink_q <= blink_d;
        end
    end

    assign blank_c = lat_c.flags[FLAG_OV] & blink_q;
`else
    logic blank_c;
    assign blank_c = 1'b0;
`endif

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  ov_q, ov_d;
    logic                  edge_digit_c;

    assign edge_digit_c = (idx_q == IDX_W'(0)) || (idx_q == IDX_W'(NUM_DIGITS - 1));

    // Glyph selection for the digit currently enabled
    always_comb begin
        an_d  = digit_enable_n(idx_q);
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        ov_d  = lat_c.flags[FLAG_OV];
        case (idx_q)
            IDX_W'(0): begin
                seg_d = lat_c.seg;
                dp_d  = lat_c.flags[FLAG_NZ];
            end
            IDX_W'(1): seg_d = lat_c.neg_n ? SEG_BLANK : SEG_MINUS;
            IDX_W'(2): seg_d = lat_c.flags[FLAG_CARRY] ? SEG_ONE : SEG_ZERO;
            default:   seg_d = lat_c.flags[FLAG_OV] ? SEG_E : SEG_BLANK;
        endcase
        if (blank_c && edge_digit_c) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            ov_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            ov_q  <= ov_d;
        end
    end

    assign bus.an_n    = an_q;
    assign bus.seg_out = seg_q;
    assign bus.dp_n    = dp_q;
    assign bus.ov_led  = ov_q;
    assign bus.upd     = upd_c;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: stimulus queues expected display
// samples and upd cycles, a negedge monitor pops and compares them.
module tb_seg_scan_display;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned STABLE_CYC   = 3;
    localparam int unsigned BLINK_FRAMES = 2;
`ifdef SEG_SCAN_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ov;
        string      tag;
    } exp_t;

    logic clk  = 1'b0;
    logic clrn = 1'b0;

    seg_scan_display_if bus();

    seg_scan_display #(
        .SCAN_DIV     (SCAN_DIV),
        .STABLE_CYC   (STABLE_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release
    int cyc = 0;
    always @(posedge clk or negedge clrn) begin
        if (!clrn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    exp_t dq[$];
    int   uq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        exp_t e;
        while (dq.size() > 0 && dq[0].cyc <= cyc) begin
            e = dq.pop_front();
            n_cmp++;
            if (e.cyc != cyc || bus.an_n !== e.an || bus.seg_out !== e.seg ||
                bus.dp_n !== e.dp || bus.ov_led !== e.ov) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: got an=%b seg=%b dp=%b ov=%b, need cyc=%0d an=%b seg=%b dp=%b ov=%b",
                         e.tag, cyc, bus.an_n, bus.seg_out, bus.dp_n, bus.ov_led,
                         e.cyc, e.an, e.seg, e.dp, e.ov);
            end
        end
        if (bus.upd === 1'b1) begin
            n_cmp++;
            if (uq.size() == 0) begin
                n_fail++;
                $display("FAIL upd_unexpected cyc=%0d: got upd=1, need 0", cyc);
            end else if (uq[0] != cyc) begin
                n_fail++;
                $display("FAIL upd_cycle: got pulse at cyc=%0d, need cyc=%0d", cyc, uq[0]);
                void'(uq.pop_front());
            end else begin
                void'(uq.pop_front());
            end
        end else if (bus.upd !== 1'b0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL upd_unknown cyc=%0d: got upd=%b, need 0/1", cyc, bus.upd);
        end else if (uq.size() > 0 && uq[0] < cyc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL upd_missing: got no pulse by cyc=%0d, need pulse at cyc=%0d", cyc, uq[0]);
            void'(uq.pop_front());
        end
    end

    task automatic drive(input logic [6:0] s, input logic n, input logic [2:0] f);
        bus.seg_in = s;
        bus.neg_n  = n;
        bus.flags  = f;
    endtask

    task automatic push_disp(input int k, input logic [3:0] an, input logic [6:0] seg,
                             input logic dp, input logic ov, input string tag);
        exp_t e;
        e.cyc = k; e.an = an; e.seg = seg; e.dp = dp; e.ov = ov; e.tag = tag;
        dq.push_back(e);
    endtask

    // Digit d is on screen for output cycles k with ((k-1)/4)%4 == d; blink half-period is 32 cycles
    task automatic push_frame(input int k0, input int n,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic dp0, input logic ov, input logic blinky,
                              input string tag);
        for (int k = k0; k < k0 + n; k++) begin
            int   d;
            logic bl;
            d  = ((k - 1) >> 2) & 3;
            bl = blinky && ((((k - 1) >> 5) & 1) == 1);
            case (d)
                0:       push_disp(k, 4'b1110, bl ? 7'h7F : s0, bl ? 1'b1 : dp0, ov, tag);
                1:       push_disp(k, 4'b1101, s1, 1'b1, ov, tag);
                2:       push_disp(k, 4'b1011, s2, 1'b1, ov, tag);
                default: push_disp(k, 4'b0111, bl ? 7'h7F : s3, 1'b1, ov, tag);
            endcase
        end
    endtask

    task automatic wait_until(input int target);
        int guard = 0;
        while (cyc < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_timeout: got cyc=%0d, need cyc=%0d", cyc, target);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((dq.size() > 0 || uq.size() > 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t, need finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int guard;

        // Reset state, then first latch of the value present at release
        drive(7'h7F, 1'b1, 3'b001);
        clrn = 1'b0;
        push_disp(0, 4'b1111, 7'h7F, 1'b1, 1'b0, "reset_state");
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        uq.push_back(6);
        for (int k = 1; k <= 4; k++) push_disp(k, 4'b1110, 7'h7F, 1'b0, 1'b0, "pre_latch");
        push_frame(7, 16, 7'h7F, 7'h7F, 7'b1000000, 7'h7F, 1'b1, 1'b0, 1'b0, "first_latch");
        wait_until(24);

        // Negative '2', nonzero
        c = cyc;
        drive(7'b0100100, 1'b0, 3'b001);
        uq.push_back(c + 6);
        push_frame(c + 7, 16, 7'b0100100, 7'b0111111, 7'b1000000, 7'h7F, 1'b1, 1'b0, 1'b0, "digit_two");
        wait_until(c + 24);

        // Bouncing input: no upd until held
        for (int i = 0; i < 10; i++) begin
            drive(7'(i * 9 + 3), 1'b0, 3'b001);
            repeat (2) @(negedge clk);
        end
        c = cyc;
        drive(7'b0110000, 1'b0, 3'b001);
        uq.push_back(c + 6);
        push_frame(c + 7, 16, 7'b0110000, 7'b0111111, 7'b1000000, 7'h7F, 1'b1, 1'b0, 1'b0, "after_bounce");
        wait_until(c + 24);

        // Overflow: E digit, ov_led, blink when enabled
        c = cyc;
        drive(7'b0100100, 1'b1, 3'b010);
        uq.push_back(c + 6);
        push_frame(c + 7, 64, 7'b0100100, 7'h7F, 7'b1000000, 7'b0000110, 1'b0, 1'b1, BLINK_ON, "overflow");
        wait_until(c + 72);

        // Zero result with carry clear
        c = cyc;
        drive(7'b1000000, 1'b1, 3'b000);
        uq.push_back(c + 6);
        push_frame(c + 7, 16, 7'b1000000, 7'h7F, 7'b1000000, 7'h7F, 1'b0, 1'b0, 1'b0, "zero_result");
        wait_until(c + 24);

        // Asynchronous reset in the middle of digit 2
        drain();
        guard = 0;
        while (((((cyc - 1) >> 2) & 3) != 2) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 clrn = 1'b0;
        push_disp(0, 4'b1111, 7'h7F, 1'b1, 1'b0, "async_reset");
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        uq.push_back(6);
        for (int k = 1; k <= 4; k++) push_disp(k, 4'b1110, 7'h7F, 1'b0, 1'b0, "restart_digit0");
        push_frame(7, 16, 7'b1000000, 7'h7F, 7'b1000000, 7'h7F, 1'b0, 1'b0, 1'b0, "after_reset");
        wait_until(24);

        drain();
        repeat (4) @(negedge clk);
        while (dq.size() > 0) begin
            exp_t e;
            e = dq.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL %s_unchecked: got no sample, need cyc=%0d", e.tag, e.cyc);
        end
        while (uq.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL upd_unseen: got no pulse, need cyc=%0d", uq[0]);
            void'(uq.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream display stage for the 4-bit sign-magnitude add/sub unit.
- Consumes its active-low segment pattern, active-low sign, and 3-bit flag word {carry, overflow, nonzero}.
- Debounces these against switch bounce and latches the result.
- Time-multiplexes the result onto a 4-digit common-anode seven-segment display: magnitude, sign, carry and error digits, with overflow blink.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays enabled (>=2).
- STABLE_CYC, 16, consecutive cycles the synchronised inputs must be unchanged before they are latched (>=1).
- BLINK_FRAMES, 25, full 4-digit scan frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- seg_in  in  7  active-low segment pattern {g..a} from the arithmetic stage.
- neg_n  in  1  active-low negative-result flag.
- flags  in  3  [2] carry-out, [1] overflow, [0] magnitude nonzero.
- an_n  out  4  active-low digit enables, one-hot-low.
- seg_out  out  7  active-low segments {g..a}.
- dp_n  out  1  active-low decimal point.
- ov_led  out  1  latched overflow indicator.
- upd  out  1  one-cycle pulse when a new result is latched.

Behaviour:
- Clock and reset: one clock, clk. Reset clrn is asynchronous, active-low. All flops are reset by clrn.
- Reset values:
  - an_n=4'b1111, seg_out=7'h7F, dp_n=1, ov_led=0, upd=0.
  - Latched word = {seg 7'h7F, neg_n 1, flags 3'b000}.
  - Scan index 0, divider 0, frame counter 0, blink phase 0, stability counter 0.
- Input stage: the 11-bit word {seg_in, neg_n, flags} passes through a 2-flop synchroniser to give sync.
  - sync_d = sync delayed one cycle.
  - Stability counter: if sync != sync_d it clears to 0; else it increments, saturating at STABLE_CYC.
  - On the cycle the counter steps from STABLE_CYC-1 to STABLE_CYC, the latch loads sync and upd=1 that same cycle.
  - upd fires once per stable value, even if the value equals the already-latched one.
  - Latency from a pin change (inputs then held) to the latch update: 2+STABLE_CYC+1 cycles.
  - Any change before saturation restarts the count; no latch load occurs.
- Scan divider: counts 0..SCAN_DIV-1. At wrap, the index steps 0->1->2->3->0.
  - Index 3->0 wrap marks end of frame and increments the frame counter (0..BLINK_FRAMES-1).
  - Frame-counter wrap toggles blink phase.
- Outputs are registered and reflect the current index and latch contents, with 1-cycle latency. an_n = ~(4'b0001<<index).
- Digit 0 (magnitude):
  - seg_out = latched seg.
  - dp_n=0 when latched flags[0]==0 (zero result), else 1.
- Digit 1 (sign): seg_out = 7'b0111111 (segment g only) if latched neg_n==0, else 7'h7F.
- Digit 2 (carry): seg_out = 7'b1111001 ('1') if flags[2], else 7'b1000000 ('0').
- Digit 3 (error): seg_out = 7'b0000110 ('E') if flags[1], else 7'h7F.
- dp_n=1 on digits 1-3.
- ov_led = latched flags[1], registered.
- A latch update mid-digit is visible on the next cycle's outputs; the scan is not restarted.
- Reset mid-scan: outputs blank immediately, regardless of clk.

Optional Feature:
- Macro: SEG_SCAN_BLINK_EN.
- Defined: while latched flags[1]==1 and blink phase==1, digits 0 and 3 output 7'h7F with dp_n=1. The enables keep scanning. Blink phase keeps running whether or not overflow is set.
- Undefined: no blink logic, no frame counter; digits 0 and 3 are always steady.

Decomposition:
- Package seg_scan_pkg:
  - Constants SEG_BLANK=7'h7F, SEG_MINUS=7'b0111111, SEG_ONE=7'b1111001, SEG_ZERO=7'b1000000, SEG_E=7'b0000110, NUM_DIGITS=4.
  - Typedef for the 11-bit latched result struct {seg, neg_n, flags}.
- Sub-module in_stable: synchroniser + stability counter + latch + upd, parameterised by width and STABLE_CYC.

Test Plan (all with SCAN_DIV=4, STABLE_CYC=3, BLINK_FRAMES=2):
- Reset, then release -> an_n=1111, seg_out=7F, upd=0 until the first stable sample. The latch loads the input present at reset release after 6 cycles.
- seg_in=7'b0100100 ('2'), neg_n=0, flags=3'b001, held -> upd pulses once. Scan shows an_n=1110 seg 0100100 dp_n=1; 1101 seg 0111111; 1011 seg 1000000; 0111 seg 7F; each digit 4 cycles.
- Toggle seg_in every 2 cycles for 20 cycles, then hold -> no upd during toggling; exactly one upd 6 cycles after the hold starts.
- flags=3'b010 held, macro defined -> ov_led=1; digit 3 shows 0000110. Digits 0 and 3 blank in alternate 2-frame windows (32 cycles each).
- flags=3'b000, seg_in=7'b1000000 -> digit 0 dp_n=0; digit 1 blank.
- clrn pulsed low mid-digit-2 -> outputs blank asynchronously; scan restarts at digit 0 after release.
